// File: rtl/router_pkg.sv
// router_pkg: shared router parameters, FSM state type and link valid encoding
package router_pkg;
   localparam int PORTS     = 5;
   localparam int DATA_W    = 32;
   localparam int PKT_FLITS = 4;
   localparam int CREDITS   = 8;
   typedef enum logic [0:0] {IDLE, XFER} state_t;
   // {p, n} rail pairs; the rails are always complementary
   localparam logic [1:0] LINK_VALID = 2'b10;
   localparam logic [1:0] LINK_IDLE  = 2'b01;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
//   req     in  N   request vector
//   ptr     in  IW  index where the scan starts, wrapping modulo N
//   gnt     out N   one-hot grant, zero when nothing requests
//   gnt_idx out IW  binary index of the granted request
module rr_arbiter
   import router_pkg::*;
#(
   parameter int N = PORTS,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   int j;
   // scanning offsets downward lets the lowest offset from ptr win the overwrite
   always_comb begin
      j = 0;
      gnt_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         j = j >= N ? j - N : j;
         if (req[IW'(j)]) gnt_idx = IW'(j);
      end
      gnt = req != '0 ? N'(1) << gnt_idx : '0;
   end
endmodule

// File: rtl/outport_ctrl.sv
// outport_ctrl: output-port stage arbitrating inports round-robin onto a credit-gated link
//   clk, rst        in   clock, synchronous active-high reset
//   port_rqs_in     in   per-inport request level, held until its packet completes
//   channel_data_in in   per-inport head flit, inport i at [i*DATA_W +: DATA_W]
//   credit_in       in   pulse: downstream freed one FIFO slot
//   arb_ack         out  one-hot pop pulse to the granted inport
//   output_channel  out  registered flit on the link
//   diff_pair_p/n   out  registered link valid rails (10 = valid, 01 = idle)
//   busy            out  packet transfer in progress
module outport_ctrl
   import router_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PORTS-1:0]        port_rqs_in,
   input  logic [PORTS*DATA_W-1:0] channel_data_in,
   input  logic                    credit_in,
   output logic [PORTS-1:0]        arb_ack,
   output logic [DATA_W-1:0]       output_channel,
   output logic                    diff_pair_p,
   output logic                    diff_pair_n,
   output logic                    busy
);
   localparam int IW = $clog2(PORTS);
   localparam int CW = $clog2(CREDITS + 1);
   localparam int FW = $clog2(PKT_FLITS + 1);
   state_t            state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d, rr_ptr_q, rr_ptr_d, arb_idx;
   logic [PORTS-1:0]  arb_gnt;
   logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
   logic [FW-1:0]     flit_cnt_q, flit_cnt_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [1:0]        link_q, link_d;
   logic              send, last, credit_inc;
   rr_arbiter #(.N(PORTS)) u_arb (
      .req     (port_rqs_in),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );
   always_comb begin
      send = state_q == XFER && credit_cnt_q != '0 && port_rqs_in[grant_q];
      last = flit_cnt_q == FW'(PKT_FLITS - 1);
      arb_ack = send ? PORTS'(1) << grant_q : '0;
      // a credit arriving with a send cancels it, even when the counter is full
      credit_inc = credit_in && (send || credit_cnt_q != CW'(CREDITS));
      credit_cnt_d = send == credit_inc ? credit_cnt_q : send ? credit_cnt_q - 1'b1 : credit_cnt_q + 1'b1;
      state_d = state_q == IDLE ? (arb_gnt != '0 ? XFER : IDLE) : (send && last ? IDLE : XFER);
      grant_d = state_q == IDLE && arb_gnt != '0 ? arb_idx : grant_q;
      flit_cnt_d = send ? (last ? '0 : flit_cnt_q + 1'b1) : flit_cnt_q;
      rr_ptr_d = send && last ? (grant_q == IW'(PORTS - 1) ? '0 : grant_q + 1'b1) : rr_ptr_q;
      out_d = send ? channel_data_in[grant_q*DATA_W +: DATA_W] : out_q;
      link_d = send ? LINK_VALID : LINK_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         credit_cnt_q <= CW'(CREDITS);
         flit_cnt_q   <= '0;
         out_q        <= '0;
         link_q       <= LINK_IDLE;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         credit_cnt_q <= credit_cnt_d;
         flit_cnt_q   <= flit_cnt_d;
         out_q        <= out_d;
         link_q       <= link_d;
      end
   end
   assign output_channel = out_q;
   assign diff_pair_p    = link_q[1];
   assign diff_pair_n    = link_q[0];
   assign busy           = state_q == XFER;
endmodule

// File: tb/tb_outport_ctrl.sv
// tb_outport_ctrl: directed and random checks of outport_ctrl against a packet-level model
module tb_outport_ctrl;
   import router_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [PORTS-1:0]        port_rqs_in = '0;
   logic [PORTS*DATA_W-1:0] channel_data_in = '0;
   logic                    credit_in = 1'b0;
   logic [PORTS-1:0]        arb_ack;
   logic [DATA_W-1:0]       output_channel;
   logic                    diff_pair_p, diff_pair_n, busy;
   always #5 clk = ~clk;
   outport_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .port_rqs_in     (port_rqs_in),
      .channel_data_in (channel_data_in),
      .credit_in       (credit_in),
      .arb_ack         (arb_ack),
      .output_channel  (output_channel),
      .diff_pair_p     (diff_pair_p),
      .diff_pair_n     (diff_pair_n),
      .busy            (busy)
   );
   int checks = 0;
   int failures = 0;
   // requester side: which inports want the output, which are forced low, flit sources
   logic [PORTS-1:0]  want = '0;
   logic [PORTS-1:0]  drop = '0;
   bit                refill = 0;
   logic [DATA_W-1:0] data [PORTS];
   // reference model: current packet owner (-1 = none), flits sent, next scan start, credits
   int owner = -1;
   int sent = 0;
   int rr = 0;
   int cred = CREDITS;
   bit exp_v = 0;
   logic [DATA_W-1:0] exp_d = '0;
   // observations of the DUT
   int acks = 0;
   int last_port = -1;
   int starts[$];
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      logic [PORTS-1:0] rq, ea;
      bit snd, found;
      int p;
      rq = want & ~drop;
      port_rqs_in = rq;
      for (int i = 0; i < PORTS; i++) channel_data_in[i*DATA_W +: DATA_W] = data[i];
      snd = owner >= 0 && cred > 0 && rq[owner];
      ea = '0;
      if (snd) ea[owner] = 1'b1;
      #1;
      chk("arb_ack", arb_ack, ea);
      chk("busy", busy, owner >= 0);
      chk("link", {diff_pair_p, diff_pair_n}, exp_v ? 2'b10 : 2'b01);
      if (exp_v) chk("data", output_channel, exp_d);
      chk("credit_cnt", dut.credit_cnt_q, cred);
      for (int i = 0; i < PORTS; i++) if (arb_ack[i]) begin
         acks++;
         if (i != last_port) starts.push_back(i);
         last_port = i;
      end
      if (rst) begin
         owner = -1; sent = 0; rr = 0; cred = CREDITS; exp_v = 0;
      end else begin
         if (credit_in && !snd && cred < CREDITS) cred++;
         else if (snd && !credit_in) cred--;
         exp_v = snd;
         if (snd) begin
            exp_d = data[owner];
            data[owner]++;
            sent++;
            if (sent == PKT_FLITS) begin
               want[owner] = refill;
               rr = (owner + 1) % PORTS;
               owner = -1;
               sent = 0;
            end
         end else if (owner < 0 && rq != '0) begin
            found = 0;
            for (int k = 0; k < PORTS; k++) begin
               p = (rr + k) % PORTS;
               if (!found && rq[p]) begin owner = p; found = 1; end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < PORTS; i++) data[i] = {8'(i + 8'hB0), 24'(i * 256)};
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_out", output_channel, 0);
      // single requester on port 2
      data[2] = 32'hA0000001;
      want = 5'b00100;
      repeat (8) step();
      chk("single_acks", acks, 4);
      chk("single_cred", dut.credit_cnt_q, 4);
      chk("single_last", output_channel, 32'hA0000004);
      // credit return with saturation at full
      credit_in = 1'b1;
      repeat (5) step();
      credit_in = 1'b0;
      chk("cred_sat", dut.credit_cnt_q, CREDITS);
      // round-robin fairness with every port requesting
      do_reset();
      refill = 1; want = '1; credit_in = 1'b1;
      starts.delete(); last_port = -1;
      for (int n = 0; n < 60 && starts.size() < 6; n++) step();
      refill = 0;
      want = owner >= 0 ? PORTS'(1) << owner : '0;
      repeat (6) step();
      chk("fair_count", starts.size(), 6);
      for (int i = 0; i < 6; i++) if (i < starts.size()) chk("fair_order", starts[i], i % PORTS);
      // credit stall: two packets exhaust the credits, one pulse frees one flit
      do_reset();
      credit_in = 1'b0; want = 5'b00001; refill = 1; acks = 0;
      repeat (13) step();
      chk("stall_sent", acks, 8);
      chk("stall_cred", dut.credit_cnt_q, 0);
      acks = 0;
      repeat (4) step();
      chk("stall_none", acks, 0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      repeat (4) step();
      chk("stall_one", acks, 1);
      // send and credit together at three credits
      drop = 5'b00001; credit_in = 1'b1;
      repeat (3) step();
      chk("cred_three", dut.credit_cnt_q, 3);
      drop = '0;
      step();
      chk("cred_both", dut.credit_cnt_q, 3);
      credit_in = 1'b0; refill = 0;
      repeat (8) step();
      // request drop mid-packet while port 3 waits
      do_reset();
      want = 5'b01010; starts.delete(); last_port = -1; acks = 0;
      repeat (3) step();
      chk("drop_pre", acks, 2);
      drop = 5'b00010; acks = 0;
      repeat (3) step();
      chk("drop_gap", acks, 0);
      drop = '0;
      repeat (10) step();
      chk("drop_count", starts.size(), 2);
      if (starts.size() == 2) begin
         chk("drop_first", starts[0], 1);
         chk("drop_next", starts[1], 3);
      end
      // reset in the middle of a packet
      do_reset();
      want = 5'b10000; acks = 0;
      repeat (3) step();
      chk("mid_acks", acks, 2);
      rst = 1'b1;
      step();
      rst = 1'b0; want = '0;
      chk("mid_rr", dut.rr_ptr_q, 0);
      chk("mid_out", output_channel, 0);
      chk("mid_busy", busy, 0);
      chk("mid_cred", dut.credit_cnt_q, CREDITS);
      step();
      // random traffic, credits, owner drops and occasional resets
      for (int n = 0; n < 800; n++) begin
         rst = $urandom_range(0, 99) == 0;
         credit_in = $urandom_range(0, 2) == 0;
         for (int i = 0; i < PORTS; i++) if (!want[i] && $urandom_range(0, 7) == 0) want[i] = 1'b1;
         drop = owner >= 0 && $urandom_range(0, 6) == 0 ? PORTS'(1) << owner : '0;
         step();
      end
      rst = 1'b0; drop = '0;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
